// File: rtl/mipi_rx_lane_aligner.sv
// ---------------------------------------------------------------------------
// mipi_rx_lane_aligner
//
// Purpose:
//   Deskews per-lane byte streams from the per-lane byte aligners so that the
//   first (sync) byte of every lane leaves on the same clock cycle. Each lane
//   feeds a tapped delay line of MAX_SKEW+1 {valid, byte} stages. While lanes
//   arrive one after another, a per-lane delay counts how long that lane has
//   been waiting. Once the last lane arrives, the delays freeze and the tap
//   at that delay is forwarded, so all lanes line up.
//
// Ports:
//   clk_i          in   1         byte clock, rising edge
//   reset_i        in   1         asynchronous active-low reset
//   bytes_i        in   8*LANES   aligned bytes, lane k at [8k+7:8k]
//   bytes_valid_i  in   LANES     per-lane valid, lane k at bit k
//   lane_bytes_o   out  8*LANES   deskewed bytes, same packing as bytes_i
//   lane_valid_o   out  1         all lanes valid and mutually aligned
//   skew_error_o   out  1         one-cycle pulse on alignment failure
// ---------------------------------------------------------------------------
module mipi_rx_lane_aligner #(
  parameter int LANES    = 2,
  parameter int MAX_SKEW = 7
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [8*LANES-1:0] bytes_i,
  input  logic [LANES-1:0]   bytes_valid_i,
  output logic [8*LANES-1:0] lane_bytes_o,
  output logic               lane_valid_o,
  output logic               skew_error_o
);

  localparam int DEPTH = MAX_SKEW + 1;
  localparam int DW    = (MAX_SKEW > 0) ? $clog2(MAX_SKEW + 1) : 1;
  localparam int CW    = $clog2(MAX_SKEW + 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKEW,
    ST_ALIGNED,
    ST_WAIT_IDLE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [DW-1:0]      r_d [LANES];
  logic [DW-1:0]      w_d_next [LANES];
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_next;

  logic [8*LANES-1:0] r_lane_bytes;
  logic [8*LANES-1:0] w_lane_bytes_next;
  logic               r_lane_valid;
  logic               w_lane_valid_next;
  logic               r_skew_error;
  logic               w_skew_error_next;

  logic [LANES-1:0]   w_tap_valid;
  logic [8*LANES-1:0] w_tap_bytes;
  logic [LANES-1:0]   w_seen;
  logic               w_all_in;
  logic               w_any_in;
  logic               w_all_tap;
  logic               w_drop;

  // Per-lane delay line and tap selection.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [8:0] r_line [DEPTH];

      // Free-running shift register, independent of the FSM state.
      always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
          for (int j = 0; j < DEPTH; j++) begin
            r_line[j] <= '0;
          end
        end else begin
          r_line[0] <= {bytes_valid_i[gi], bytes_i[8*gi +: 8]};
          for (int j = 1; j < DEPTH; j++) begin
            r_line[j] <= r_line[j-1];
          end
        end
      end

      assign w_tap_valid[gi]         = r_line[r_d[gi]][8];
      assign w_tap_bytes[8*gi +: 8]  = r_line[r_d[gi]][7:0];
      // During SKEW a non-zero delay means the lane has already started.
      assign w_seen[gi]              = (r_d[gi] != '0);
    end
  endgenerate

  assign w_all_in  = &bytes_valid_i;
  assign w_any_in  = |bytes_valid_i;
  assign w_all_tap = &w_tap_valid;
  assign w_drop    = |(w_seen & ~bytes_valid_i);

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_lane_bytes <= '0;
      r_lane_valid <= 1'b0;
      r_skew_error <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        r_d[k] <= '0;
      end
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_lane_bytes <= w_lane_bytes_next;
      r_lane_valid <= w_lane_valid_next;
      r_skew_error <= w_skew_error_next;
      for (int k = 0; k < LANES; k++) begin
        r_d[k] <= w_d_next[k];
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_lane_bytes_next = r_lane_bytes;
    w_lane_valid_next = 1'b0;
    w_skew_error_next = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      w_d_next[k] = r_d[k];
    end

    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        for (int k = 0; k < LANES; k++) begin
          w_d_next[k] = '0;
        end
        if (w_all_in) begin
          w_state_next = ST_ALIGNED;
        end else if (w_any_in) begin
          w_state_next = ST_SKEW;
          w_cnt_next   = CW'(1);
          for (int k = 0; k < LANES; k++) begin
            w_d_next[k] = DW'(bytes_valid_i[k]);
          end
        end
      end

      ST_SKEW: begin
        if (w_all_in) begin
          // Freeze delays; a lane arriving now keeps d = 0.
          w_state_next = ST_ALIGNED;
        end else if (w_drop || (r_cnt >= CW'(MAX_SKEW))) begin
          w_skew_error_next = 1'b1;
          w_state_next      = ST_WAIT_IDLE;
          w_cnt_next        = '0;
          for (int k = 0; k < LANES; k++) begin
            w_d_next[k] = '0;
          end
        end else begin
          w_cnt_next = r_cnt + CW'(1);
          for (int k = 0; k < LANES; k++) begin
            if (bytes_valid_i[k]) begin
              w_d_next[k] = r_d[k] + DW'(1);
            end
          end
        end
      end

      ST_ALIGNED: begin
        if (w_all_tap) begin
          w_lane_bytes_next = w_tap_bytes;
          w_lane_valid_next = 1'b1;
        end else begin
          // Earliest-ending lane closes the burst; late trailing bytes drop.
          w_state_next = ST_WAIT_IDLE;
          w_cnt_next   = '0;
          for (int k = 0; k < LANES; k++) begin
            w_d_next[k] = '0;
          end
        end
      end

      ST_WAIT_IDLE: begin
        if (!w_any_in) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign lane_bytes_o = r_lane_bytes;
  assign lane_valid_o = r_lane_valid;
  assign skew_error_o = r_skew_error;

endmodule

// File: doc/mipi_rx_lane_aligner.md
# mipi_rx_lane_aligner

Deskews the per-lane byte streams coming out of the per-lane byte aligners so that the first (sync) byte of every lane appears on the same clock cycle. It emits one combined multi-lane word per cycle with a single valid flag to the downstream packet decoder. Lane skew up to MAX_SKEW byte clocks is absorbed with per-lane tapped delay lines. Larger skew, or a lane dropping out before the others arrive, is flagged as an error.

## Interface
- LANES, 2: number of data lanes, 1..4.
- MAX_SKEW, 7: maximum absorbable lane-to-lane skew in byte clocks; delay line depth is MAX_SKEW+1.
- clk_i  input  1  byte clock, all logic on rising edge.
- reset_i  input  1  asynchronous, active-low reset; one clock domain only.
- bytes_i  input  8*LANES  aligned bytes; lane k occupies [8k+7:8k].
- bytes_valid_i  input  LANES  per-lane valid from each byte aligner; lane k valid is bit k.
- lane_bytes_o  output  8*LANES  deskewed bytes, same lane packing as bytes_i.
- lane_valid_o  output  1  all lanes of lane_bytes_o valid and mutually aligned.
- skew_error_o  output  1  one-cycle pulse on an alignment failure.

## Operation
- Each lane has a shift register dl[k][0..MAX_SKEW] of {valid, byte}.
  - Every cycle: dl[k][0] <= {bytes_valid_i[k], bytes_i[k]}; dl[k][j] <= dl[k][j-1].
  - The shift registers keep running in every state.
- Each lane has a delay register d[k], width clog2(MAX_SKEW+1).
- There is a skew counter cnt, width clog2(MAX_SKEW+2).
- States:
  - IDLE:
    - d[k]=0 and cnt=0.
    - If all bytes_valid_i are high: go to ALIGNED, all d[k]=0.
    - Else if any bytes_valid_i is high: go to SKEW with cnt=1, and d[k]=1 for each lane already valid.
  - SKEW:
    - Each cycle, d[k] increments for every lane that is valid but not yet complete.
    - cnt increments each cycle.
    - When all bytes_valid_i are high on an edge: freeze d[k] (a lane arriving on that edge gets d=0) and go to ALIGNED.
    - If cnt would exceed MAX_SKEW, or any lane that was already valid drops valid: pulse skew_error_o and go to WAIT_IDLE.
  - ALIGNED:
    - Each cycle: lane_bytes_o[k] <= dl[k][d[k]].byte and lane_valid_o <= AND over k of dl[k][d[k]].valid.
    - The first cycle in which that AND is low after having been high clears lane_valid_o and moves to WAIT_IDLE.
  - WAIT_IDLE:
    - lane_valid_o = 0.
    - Return to IDLE when all bytes_valid_i are low.
- lane_bytes_o holds its last value when lane_valid_o is low.
- Trailing bytes of lanes that end late are discarded.
- LANES=1: the block degenerates to a 2-cycle pipeline with d[0]=0 and never raises an error.

## Timing
- Reset (asynchronous, active-low) immediately forces:
  - lane_bytes_o = 0, lane_valid_o = 0, skew_error_o = 0.
  - State = IDLE, all d, cnt and delay-line contents = 0.
- Reset asserted mid-packet aborts with no error pulse.
- Latency: let edge T be the edge where the last lane's first byte is sampled.
  - lane_valid_o rises after edge T+1, i.e. 2 cycles after that first byte is sampled.
  - The first output word holds every lane's first byte.
- d[k] = T - (edge at which lane k's first byte was sampled), so 0 <= d[k] <= MAX_SKEW.
- A skew of exactly MAX_SKEW is accepted.
- A skew of MAX_SKEW+1 raises skew_error_o on the edge where cnt passes MAX_SKEW.
- skew_error_o is high for exactly one cycle.
- After an error, no lane_valid_o is asserted until all inputs have been low for at least one cycle.
- Back-to-back packets: re-alignment needs at least one cycle with all inputs low (IDLE).
- The lane with the earliest end determines when lane_valid_o falls, with the same 2-cycle latency.

## Test plan
- LANES=2, both lanes valid on the same edge with byte sequences B8,01,02 -> lane_valid_o high 2 cycles later; lane_bytes_o = B8B8, 0101, 0202.
- Lane 1 valid 3 cycles after lane 0 -> d[0]=3, d[1]=0; the first output word is B8B8, 2 cycles after lane 1's first byte; no error.
- Skew of exactly 7 with MAX_SKEW=7 -> aligned output.
- Skew of 8 -> skew_error_o pulses once 8 cycles after lane 0's first valid; lane_valid_o stays 0 until all inputs have gone low and a new aligned burst arrives.
- Lane 0 valid for 2 cycles, then low, before lane 1 arrives -> skew_error_o pulse, then WAIT_IDLE.
- Lane 0 ends 2 cycles before lane 1 -> lane_valid_o falls when lane 0's delayed valid falls; lane 1's extra bytes are not output.
- Assert reset_i low mid-ALIGNED -> all outputs are 0 immediately; after release, a fresh aligned burst is output correctly.
